spi_regbank: RTL

SPI_REGBANK -- requirements
Module: spi_regbank

---
 rtl/spi_regbank_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_regbank.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_regbank_pkg.sv
// Shared types for the SPI register bank: FSM state encoding and R/W bit values.
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CMD    = 2'b01,
        DATA   = 2'b10,
        COMMIT = 2'b11
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI clock and chip select into theClock and flags
// rising edges of the synchronised SPI clock.
module spi_sync_edge (
    input  logic theClock,
    input  logic theReset,
    input  logic spi_clk,
    input  logic spi_cs,
    output logic sclk_rise,
    output logic cs_n_sync
);

    logic [1:0] sclk_meta_r;
    logic       sclk_prev_r;
    logic [1:0] cs_meta_r;

    // Two-flop synchronisers plus a delayed copy of spi_clk for edge detection.
    // cs resets to "asserted" so a frame in progress is never mistaken for a
    // fresh deselect right after reset.
    always_ff @(posedge theClock) begin
        if (theReset) begin
            sclk_meta_r <= 2'b00;
            sclk_prev_r <= 1'b0;
            cs_meta_r   <= 2'b00;
        end else begin
            sclk_meta_r <= {sclk_meta_r[0], spi_clk};
            sclk_prev_r <= sclk_meta_r[1];
            cs_meta_r   <= {cs_meta_r[0], spi_cs};
        end
    end

    assign sclk_rise = sclk_meta_r[1] & ~sclk_prev_r;
    assign cs_n_sync = cs_meta_r[1];

endmodule

// File: rtl/spi_regbank.sv
// SPI mode-0 slave register bank: R/W bit, address, data word, MSB first.
// Define SPI_REGBANK_BURST_EN to keep a frame going with auto-incrementing address.
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int N_REGS = 32
) (
    input  logic                       theClock,
    input  logic                       theReset,
    input  logic                       spi_clk,
    input  logic                       spi_cs,
    input  logic                       spi_sdi,
    output logic                       spi_sdo,
    output logic [N_REGS*DATA_W-1:0]   ctrl_regs,
    input  logic [N_REGS*DATA_W-1:0]   stat_regs,
    output logic                       irq,
    output logic [ADDR_W-1:0]          irq_addr
);

    localparam int CMD_W   = 1 + ADDR_W;
    localparam int CNT_MAX = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic                sclk_rise_s;
    logic                cs_n_sync_s;
    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CMD_W-1:0]    cmd_r;
    logic [DATA_W-1:0]   shift_r;
    logic [DATA_W-1:0]   ctrl_r [N_REGS];
    logic [DATA_W-1:0]   stat_arr_s [N_REGS];
    logic                irq_r;
    logic [ADDR_W-1:0]   irq_addr_r;
    logic                armed_r;
    logic [CMD_W-1:0]    cmd_next_s;
    logic                rw_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [ADDR_W-1:0]   addr_inc_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic                addr_ok_s;

    spi_sync_edge u_sync (
        .theClock  (theClock),
        .theReset  (theReset),
        .spi_clk   (spi_clk),
        .spi_cs    (spi_cs),
        .sclk_rise (sclk_rise_s),
        .cs_n_sync (cs_n_sync_s)
    );

    for (genvar g = 0; g < N_REGS; g++) begin : g_pack
        assign ctrl_regs[g*DATA_W +: DATA_W] = ctrl_r[g];
        assign stat_arr_s[g]                 = stat_regs[g*DATA_W +: DATA_W];
    end

    assign cmd_next_s = {cmd_r[CMD_W-2:0], spi_sdi};
    assign rw_s       = cmd_r[CMD_W-1];
    assign addr_s     = cmd_r[ADDR_W-1:0];
    assign addr_ok_s  = ({1'b0, addr_s} < (ADDR_W+1)'(N_REGS));

    // Next burst address, wrapping at the top of the implemented range.
    always_comb begin
        if (addr_s == ADDR_W'(N_REGS - 1)) begin
            addr_inc_s = '0;
        end else begin
            addr_inc_s = addr_s + ADDR_W'(1);
        end
    end

    // Read address: the one just shifted in at the end of CMD, else the next burst word.
    always_comb begin
        if (state_r == CMD) begin
            rd_addr_s = cmd_next_s[ADDR_W-1:0];
        end else begin
            rd_addr_s = addr_inc_s;
        end
    end

    // Status lookup; unimplemented addresses read back as all ones.
    always_comb begin
        rd_word_s = '1;
        for (int i = 0; i < N_REGS; i++) begin
            rd_word_s = (rd_addr_s == ADDR_W'(i)) ? stat_arr_s[i] : rd_word_s;
        end
    end

    // Frame FSM, shift register and irq generation.
    always_ff @(posedge theClock) begin
        if (theReset) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            cmd_r      <= '0;
            shift_r    <= '0;
            irq_r      <= 1'b0;
            irq_addr_r <= '0;
            armed_r    <= 1'b0;
        end else begin
            irq_r <= 1'b0;
            if (cs_n_sync_s) begin
                armed_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    shift_r <= '0;
                    // armed_r blocks re-entry until cs has been seen high.
                    if (!cs_n_sync_s && armed_r) begin
                        state_r <= CMD;
                        cnt_r   <= '0;
                        cmd_r   <= '0;
                    end
                end
                CMD: begin
                    if (cs_n_sync_s) begin
                        state_r <= IDLE;
                    end else if (sclk_rise_s) begin
                        cmd_r <= cmd_next_s;
                        if (cnt_r == CNT_W'(CMD_W - 1)) begin
                            state_r <= DATA;
                            cnt_r   <= '0;
                            shift_r <= (cmd_next_s[CMD_W-1] == RW_READ) ? rd_word_s : '0;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (cs_n_sync_s) begin
                        state_r <= IDLE;
                        shift_r <= '0;
                    end else if (sclk_rise_s) begin
                        shift_r <= {shift_r[DATA_W-2:0], spi_sdi};
                        if (cnt_r == CNT_W'(DATA_W - 1)) begin
                            state_r <= COMMIT;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    if ((rw_s == RW_WRITE) && addr_ok_s) begin
                        irq_r      <= 1'b1;
                        irq_addr_r <= addr_s;
                    end
`ifdef SPI_REGBANK_BURST_EN
                    if (!cs_n_sync_s) begin
                        state_r            <= DATA;
                        cnt_r              <= '0;
                        cmd_r[ADDR_W-1:0]  <= addr_inc_s;
                        shift_r            <= (rw_s == RW_READ) ? rd_word_s : '0;
                    end else begin
                        state_r <= IDLE;
                        shift_r <= '0;
                    end
`else
                    state_r <= IDLE;
                    shift_r <= '0;
                    armed_r <= 1'b0;
`endif
                end
                default: begin
                    state_r <= IDLE;
                    shift_r <= '0;
                end
            endcase
        end
    end

    // Register file write port; out-of-range addresses match no entry.
    always_ff @(posedge theClock) begin
        if (theReset) begin
            for (int i = 0; i < N_REGS; i++) begin
                ctrl_r[i] <= '0;
            end
        end else if ((state_r == COMMIT) && (rw_s == RW_WRITE)) begin
            for (int i = 0; i < N_REGS; i++) begin
                if (addr_s == ADDR_W'(i)) begin
                    ctrl_r[i] <= shift_r;
                end
            end
        end
    end

    assign spi_sdo  = shift_r[DATA_W-1];
    assign irq      = irq_r;
    assign irq_addr = irq_addr_r;

endmodule
